// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// ALU control codes, MDU states and a sign helper.
package mdu_ctrl_pkg;

   localparam logic [4:0] MULT_CONTROL  = 5'b11000;
   localparam logic [4:0] MULTU_CONTROL = 5'b11001;
   localparam logic [4:0] DIV_CONTROL   = 5'b11010;
   localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } mdu_state_e;

   function automatic logic [31:0] neg_if(
      input logic        neg,
      input logic [31:0] v
   );
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Restoring divider datapath: one shift/subtract step per step_i.
// rem_o/quo_o show the result of the step taken on the coming edge.
module div_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic [31:0] quo_o
);

   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        ge;

   // rem stays below the divisor, so the 33-bit borrow is a clean compare
   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {1'b0, dvs_q};
   assign ge      = ~diff[32];
   assign rem_o   = ge ? diff[31:0] : shifted[31:0];
   assign quo_o   = {quo_q[30:0], ge};

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      if (load_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
      end else if (step_i) begin
         rem_d = rem_o;
         quo_d = quo_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO.
// Single-cycle multiply, 32-step restoring divide, MTHI/MTLO writes.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  alu_control,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        stall_o,
   output logic        done_o,
   output logic        div_zero_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [4:0] LAST_CNT = 5'(DIV_STEPS - 1);

   mdu_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        dz_q, dz_d;
   logic        qs_q, qs_d;
   logic        rs_q, rs_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_mul, is_div, is_sgn;
   logic        md_start, b_zero, last;
   logic        stall, load, step;
   logic [31:0] a_abs, b_abs;
   logic [31:0] rem_nxt, quo_nxt;
   logic [63:0] mul_a, mul_b, prod;

   assign is_mul = (alu_control == MULT_CONTROL)
                 | (alu_control == MULTU_CONTROL);
   assign is_div = (alu_control == DIV_CONTROL)
                 | (alu_control == DIVU_CONTROL);
   assign is_sgn = (alu_control == MULT_CONTROL)
                 | (alu_control == DIV_CONTROL);

   assign md_start = start & (is_mul | is_div) & ~flush;
   assign b_zero   = (src_b == 32'd0);
   assign last     = (cnt_q == LAST_CNT);

   // sign-extending for MULT makes the low 64 bits the signed product
   assign mul_a = {{32{is_sgn & src_a[31]}}, src_a};
   assign mul_b = {{32{is_sgn & src_b[31]}}, src_b};
   assign prod  = mul_a * mul_b;

   assign a_abs = neg_if(is_sgn & src_a[31], src_a);
   assign b_abs = neg_if(is_sgn & src_b[31], src_b);

   div_core u_div (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .step_i     (step),
      .dividend_i (a_abs),
      .divisor_i  (b_abs),
      .rem_o      (rem_nxt),
      .quo_o      (quo_nxt)
   );

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            stall = md_start;
            if (md_start) begin
               if (is_mul || b_zero) begin
                  state_d = S_DONE;
               end else begin
                  load    = 1'b1;
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            stall = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               step = 1'b1;
               if (last) state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      dz_d  = dz_q;
      qs_d  = qs_q;
      rs_d  = rs_q;
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
         qs_d  = is_sgn & (src_a[31] ^ src_b[31]);
         rs_d  = is_sgn & src_a[31];
      end else if (step) begin
         cnt_d = cnt_q + 5'd1;
      end
      if (state_q == S_IDLE) begin
         if (md_start) begin
            if (is_mul) begin
               hi_d = prod[63:32];
               lo_d = prod[31:0];
            end else if (b_zero) begin
               dz_d = 1'b1;
            end
         end else begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
         end
      end
      if (step && last) begin
         lo_d = neg_if(qs_q, quo_nxt);
         hi_d = neg_if(rs_q, rem_nxt);
      end
      if (state_q == S_DONE) dz_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         qs_q    <= 1'b0;
         rs_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         qs_q    <= qs_d;
         rs_q    <= rs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // an asserted reset must drop the stall even while EX still holds start
   assign stall_o    = stall & ~rst;
   assign div_zero_o = (state_q == S_DONE) & dz_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with an arithmetic reference model
// checked every cycle plus literal expectations from hand calculation.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  alu_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        stall_o;
   logic        done_o;
   logic        div_zero_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int total = 0;
   int bad   = 0;

   mdu_ctrl #(.DIV_STEPS(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .flush       (flush),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .stall_o     (stall_o),
      .done_o      (done_o),
      .div_zero_o  (div_zero_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic is_md(input logic [4:0] c);
      return c == MULT_CONTROL || c == MULTU_CONTROL ||
             c == DIV_CONTROL  || c == DIVU_CONTROL;
   endfunction

   // {hi, lo} an MD instruction must leave behind
   function automatic logic [63:0] md_result(input logic [4:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      if (op == MULT_CONTROL) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         p = 64'(sa * sb);
         return p;
      end
      if (op == MULTU_CONTROL) begin
         p = {32'd0, a} * {32'd0, b};
         return p;
      end
      if (op == DIV_CONTROL) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // reference model: busy countdown, pending result, one-cycle done
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   int          m_wait;
   logic        m_done, m_dz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
         m_wait <= 0; m_done <= 1'b0; m_dz <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_dz   <= 1'b0;
      end else if (m_wait > 0) begin
         if (flush) begin
            m_wait <= 0;
         end else begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
               m_hi   <= p_hi;
               m_lo   <= p_lo;
               m_done <= 1'b1;
            end
         end
      end else if (start && !flush && is_md(alu_control)) begin
         if (alu_control == MULT_CONTROL ||
             alu_control == MULTU_CONTROL) begin
            {m_hi, m_lo} <= md_result(alu_control, src_a, src_b);
            m_done <= 1'b1;
         end else if (src_b == 32'd0) begin
            m_done <= 1'b1;
            m_dz   <= 1'b1;
         end else begin
            {p_hi, p_lo} <= md_result(alu_control, src_a, src_b);
            m_wait <= 32;
         end
      end else begin
         if (hi_we) m_hi <= wdata;
         if (lo_we) m_lo <= wdata;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_stall", 32'(stall_o), 32'd0);
         chk("rst_done", 32'(done_o), 32'd0);
         chk("rst_hi", hi_o, 32'd0);
         chk("rst_lo", lo_o, 32'd0);
      end else begin
         chk("stall", 32'(stall_o), 32'(m_wait > 0 ||
             (!m_done && start && !flush && is_md(alu_control))));
         chk("done", 32'(done_o), 32'(m_done));
         chk("dz", 32'(div_zero_o), 32'(m_dz));
         chk("hi", hi_o, m_hi);
         chk("lo", lo_o, m_lo);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // present op from cycle 0 until done; returns done cycle and stalls
   task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int dcyc,
                         output int nstall, output logic dz);
      start = 1'b1;
      alu_control = op;
      src_a = a;
      src_b = b;
      dcyc = -1;
      nstall = 0;
      dz = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (stall_o) nstall++;
         if (done_o) begin
            dcyc = n;
            dz = div_zero_o;
            break;
         end
         cyc();
      end
      if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
      cyc();
      start = 1'b0;
   endtask

   int   dc, ns, cnt;
   logic dz;

   initial begin
      rst = 1'b1; start = 1'b0; alu_control = '0; src_a = '0;
      src_b = '0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      wdata = '0;
      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_hi", hi_o, 32'd0);
      chk("reset_lo", lo_o, 32'd0);
      chk("reset_stall", 32'(stall_o), 32'd0);
      chk("reset_done", 32'(done_o), 32'd0);
      cyc();

      run_op(MULT_CONTROL, 32'hFFFF_FFFE, 32'd3, dc, ns, dz);
      chk("mult_dcyc", 32'(dc), 32'd1);
      chk("mult_stalls", 32'(ns), 32'd1);
      chk("mult_hi", hi_o, 32'hFFFF_FFFF);
      chk("mult_lo", lo_o, 32'hFFFF_FFFA);

      run_op(MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, ns, dz);
      chk("multu_hi", hi_o, 32'hFFFF_FFFE);
      chk("multu_lo", lo_o, 32'h0000_0001);

      run_op(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, dc, ns, dz);
      chk("div_dcyc", 32'(dc), 32'd33);
      chk("div_stalls", 32'(ns), 32'd33);
      chk("div_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_hi", hi_o, 32'hFFFF_FFFF);

      run_op(DIVU_CONTROL, 32'd100, 32'd7, dc, ns, dz);
      chk("divu_lo", lo_o, 32'd14);
      chk("divu_hi", hi_o, 32'd2);
      run_op(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, dc, ns, dz);
      chk("b2b_dcyc", 32'(dc), 32'd33);
      chk("ovf_lo", lo_o, 32'h8000_0000);
      chk("ovf_hi", hi_o, 32'd0);

      // MD start beats a simultaneous MTHI
      hi_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
      run_op(MULTU_CONTROL, 32'd2, 32'd3, dc, ns, dz);
      hi_we = 1'b0;
      chk("mdwin_hi", hi_o, 32'd0);
      chk("mdwin_lo", lo_o, 32'd6);

      // non-MD code must be ignored
      start = 1'b1;
      alu_control = 5'd0;
      @(negedge clk);
      chk("nonmd_stall", 32'(stall_o), 32'd0);
      cyc();
      start = 1'b0;

      hi_we = 1'b1; wdata = 32'h11;
      cyc();
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
      cyc();
      lo_we = 1'b0;
      run_op(DIV_CONTROL, 32'd5, 32'd0, dc, ns, dz);
      chk("dz_dcyc", 32'(dc), 32'd1);
      chk("dz_flag", 32'(dz), 32'd1);
      chk("dz_hi", hi_o, 32'h11);
      chk("dz_lo", lo_o, 32'h22);

      start = 1'b1; alu_control = DIV_CONTROL;
      src_a = 32'd100; src_b = 32'd3;
      for (int i = 0; i < 10; i++) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("flush_stall", 32'(stall_o), 32'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) cnt++;
      end
      chk("flush_nodone", 32'(cnt), 32'd0);
      chk("flush_hi", hi_o, 32'h11);
      chk("flush_lo", lo_o, 32'h22);
      cyc();

      start = 1'b1; alu_control = DIV_CONTROL;
      src_a = 32'd1000; src_b = 32'd3;
      for (int i = 0; i < 5; i++) cyc();
      #1 rst = 1'b1;
      #1;
      chk("arst_stall", 32'(stall_o), 32'd0);
      chk("arst_done", 32'(done_o), 32'd0);
      chk("arst_dz", 32'(div_zero_o), 32'd0);
      chk("arst_hi", hi_o, 32'd0);
      chk("arst_lo", lo_o, 32'd0);
      cyc();
      start = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      chk("post_rst_hi", hi_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the EX stage. Accepts MULT/MULTU/DIV/DIVU from the ALU decoder's `ALUControl` code, runs a single-cycle multiply or a 32-iteration restoring divide, owns the HI/LO registers, and holds the pipeline stalled until the result is committed. It also services MTHI/MTLO writes.

## Interface
Parameters:
- `DIV_STEPS`, default 32: number of divide iterations; fixed at 32 for the 32-bit datapath.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  EX holds a valid instruction.
- `alu_control`  in  5  `ALUControl` code. Only `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL` and `DIVU_CONTROL` act; every other code is ignored.
- `src_a`  in  32  rs operand (dividend / multiplicand).
- `src_b`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  cancel the current operation.
- `hi_we`, `lo_we`  in  1  MTHI / MTLO write enables.
- `wdata`  in  32  MTHI / MTLO data.
- `stall_o`  out  1  freeze IF/ID/EX.
- `done_o`  out  1  one-cycle pulse when an operation completes.
- `div_zero_o`  out  1  pulses together with `done_o` when the divisor was 0.
- `hi_o`, `lo_o`  out  32  HI/LO register contents.

## Operation
- State machine with three states: IDLE, DIV, DONE.
- A "md start" is: `start=1`, `alu_control` is one of the four MD codes, and `flush=0`.

IDLE
- `stall_o` is combinational and equals md start.
- MULT/MULTU with md start:
  - Compute the 64-bit signed (MULT) or unsigned (MULTU) product.
  - On the edge, HI gets product[63:32] and LO gets product[31:0].
  - Next state: DONE.
- DIV/DIVU with md start and `src_b != 0`:
  - Latch the absolute values of the operands (raw values for DIVU).
  - Latch the quotient sign (`src_a[31]^src_b[31]`) and the remainder sign (`src_a[31]`). Both signs are 0 for DIVU.
  - Clear the remainder and the counter.
  - Next state: DIV.
- DIV/DIVU with md start and `src_b == 0`:
  - Next state: DONE with the div-zero flag set.
  - HI/LO are unchanged.
- `hi_we`/`lo_we` write `wdata` on the edge. They are honored only when there is no md start; an md start wins.

DIV
- `stall_o=1`.
- Each cycle performs one restoring step:
  - shift {rem, quo} left by 1;
  - if rem is at least the divisor, subtract the divisor and set quo[0].
- The counter runs from 0 to 31.
- On the edge with counter==31:
  - LO gets the quotient, negated if the quotient sign is set.
  - HI gets the remainder, negated if the remainder sign is set.
  - Next state: DONE.
- MTHI/MTLO writes are ignored.

DONE
- `stall_o=0`, `done_o=1`, and `div_zero_o` equals the latched flag.
- `start` is ignored, because EX still presents the completed instruction.
- Next state: IDLE unconditionally. The flag is cleared.

Flush
- In DIV, `flush` moves the block to IDLE on the next edge. HI/LO are not written and `done_o` does not pulse.
- A flush in the same cycle as `start` means the start is not accepted.
- A flush in DONE has no effect.

Arithmetic
- The divider datapath is 32-bit; negation is two's complement.
- 0x80000000 / −1 yields LO=0x80000000, HI=0 (natural wrap; no trap).

## Timing
- Reset values: HI=0, LO=0, `stall_o=0`, `done_o=0`, `div_zero_o=0`, state IDLE, counter 0.
- `rst` asserted mid-operation aborts immediately to the reset values.
- MULT/MULTU: stall for cycle 0 only. HI/LO are valid and `done_o=1` in cycle 1.
- DIV/DIVU: stall in cycles 0–32 (33 cycles). HI/LO are valid and `done_o=1` in cycle 33.
- Divide by zero: stall in cycle 0. `done_o=1` and `div_zero_o=1` in cycle 1.
- Back-to-back MD instructions: the second is accepted in the cycle after DONE.
- `hi_o`/`lo_o` are register outputs and carry no combinational path from the inputs.

## Structure
- Add `DIV_CONTROL` and `DIVU_CONTROL` to `defines2.vh`, using unused 5-bit codes. Also add the MDU state encodings (IDLE=2'd0, DIV=2'd1, DONE=2'd2) there.
- One sub-module, `div_core`: a restoring-divider datapath. It has load/step inputs and exposes rem/quo. The FSM, the sign handling and HI/LO stay in `mdu_ctrl`.

## Test plan
- MULT with 0xFFFFFFFE × 3: `stall_o` high for 1 cycle; `done_o` in cycle 1; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2: 33 stall cycles; `done_o` in cycle 33; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7, then DIV 0x80000000 / 0xFFFFFFFF back-to-back:
  - first result LO=14, HI=2;
  - second result LO=0x80000000, HI=0;
  - the second operation starts in the cycle after the first DONE.
- DIV 5 / 0 with HI/LO preloaded by MTHI/MTLO to 0x11/0x22: `done_o` and `div_zero_o` in cycle 1; HI=0x11, LO=0x22 unchanged.
- Abort cases:
  - `flush` in DIV cycle 10: `stall_o` falls next cycle; no `done_o`; HI/LO unchanged.
  - Async `rst` in DIV cycle 5: all outputs go to 0 immediately.
